// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: per-unit result handshake in, register file write port and forwarding port out.
// The slave modport is the arbiter's view; master is the execution-unit / register-file side.
interface regfile_wb_arbiter_if #(
    parameter int XLEN      = 32,
    parameter int NUM_UNITS = 3
);
    logic [NUM_UNITS-1:0]           unit_valid;
    logic [NUM_UNITS-1:0]           unit_ready;
    logic [NUM_UNITS-1:0][1:0]      unit_thread;
    logic [NUM_UNITS-1:0][4:0]      unit_rd;
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_data;

    logic                           wr_en;
    logic [1:0]                     thread_rd_id;
    logic [4:0]                     rd_addr;
    logic [XLEN-1:0]                new_data;

    logic                           byp_valid;
    logic [1:0]                     byp_thread;
    logic [4:0]                     byp_rd;
    logic [XLEN-1:0]                byp_data;

    modport slave (
        input  unit_valid, unit_thread, unit_rd, unit_data,
        output unit_ready,
        output wr_en, thread_rd_id, rd_addr, new_data,
        output byp_valid, byp_thread, byp_rd, byp_data
    );

    modport master (
        output unit_valid, unit_thread, unit_rd, unit_data,
        input  unit_ready,
        input  wr_en, thread_rd_id, rd_addr, new_data,
        input  byp_valid, byp_thread, byp_rd, byp_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: one FIFO per execution unit, one registered register-file write per cycle.
// Define REGFILE_WB_BYPASS_EN to register the previous cycle's write port onto the byp_* forwarding outputs.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_UNITS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int UW = $clog2(NUM_UNITS);

    typedef struct packed {
        logic [1:0]      thread;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t            fifo_mem [NUM_UNITS][FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr   [NUM_UNITS];
    logic [PW-1:0]        rd_ptr   [NUM_UNITS];
    logic [CW-1:0]        count    [NUM_UNITS];
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] ready;

    logic                 grant_valid;
    logic [UW-1:0]        grant_idx;
    logic [UW-1:0]        rr_ptr;
    wb_entry_t            head;

    logic                 wr_en_q;
    logic [1:0]           thread_q;
    logic [4:0]           rd_q;
    logic [XLEN-1:0]      data_q;

    // Unit index base+k, wrapped modulo NUM_UNITS (which need not be a power of two).
    function automatic logic [UW-1:0] wrap_add(input logic [UW-1:0] base, input int k);
        logic [UW:0] sum;
        sum = {1'b0, base} + (UW+1)'(k);
        if (sum >= (UW+1)'(NUM_UNITS))
            sum = sum - (UW+1)'(NUM_UNITS);
        return sum[UW-1:0];
    endfunction

    always_comb begin
        ready = '0;
        push  = '0;
        pop   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            ready[i] = (count[i] != CW'(FIFO_DEPTH));
            push[i]  = bus.unit_valid[i] && ready[i];
            pop[i]   = grant_valid && (grant_idx == UW'(i));
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!grant_valid && (count[wrap_add(rr_ptr, k)] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign head = fifo_mem[grant_idx][rd_ptr[grant_idx]];

    // Storage carries no reset; validity is tracked entirely by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (push[i] && !flush)
                fifo_mem[i][wr_ptr[i]] <= '{thread: bus.unit_thread[i],
                                            rd:     bus.unit_rd[i],
                                            data:   bus.unit_data[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CW'(1);
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - CW'(1);
            end
        end
    end

    // Writes to r0 still pop and use the slot, but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            wr_en_q  <= 1'b0;
            thread_q <= '0;
            rd_q     <= '0;
            data_q   <= '0;
        end else if (flush) begin
            rr_ptr   <= '0;
            wr_en_q  <= 1'b0;
        end else if (grant_valid) begin
            rr_ptr   <= wrap_add(grant_idx, 1);
            wr_en_q  <= (head.rd != 5'd0);
            thread_q <= head.thread;
            rd_q     <= head.rd;
            data_q   <= head.data;
        end else begin
            wr_en_q  <= 1'b0;
        end
    end

    assign bus.unit_ready   = ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.thread_rd_id = thread_q;
    assign bus.rd_addr      = rd_q;
    assign bus.new_data     = data_q;

`ifdef REGFILE_WB_BYPASS_EN
    logic            byp_valid_q;
    logic [1:0]      byp_thread_q;
    logic [4:0]      byp_rd_q;
    logic [XLEN-1:0] byp_data_q;

    // Delayed copy of the write port covers the register file's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_valid_q  <= 1'b0;
            byp_thread_q <= '0;
            byp_rd_q     <= '0;
            byp_data_q   <= '0;
        end else if (flush) begin
            byp_valid_q  <= 1'b0;
        end else begin
            byp_valid_q  <= wr_en_q;
            byp_thread_q <= thread_q;
            byp_rd_q     <= rd_q;
            byp_data_q   <= data_q;
        end
    end

    assign bus.byp_valid  = byp_valid_q;
    assign bus.byp_thread = byp_thread_q;
    assign bus.byp_rd     = byp_rd_q;
    assign bus.byp_data   = byp_data_q;
`else
    assign bus.byp_valid  = 1'b0;
    assign bus.byp_thread = '0;
    assign bus.byp_rd     = '0;
    assign bus.byp_data   = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (3 units, depth 4); bypass expectations
// follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NU   = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   num_compared   = 0;
    int   num_mismatched = 0;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .NUM_UNITS(NU)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .NUM_UNITS(NU), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int u, input logic valid, input logic [1:0] thread,
                                 input logic [4:0] rd, input logic [31:0] data);
        bus.unit_valid[u]  = valid;
        bus.unit_thread[u] = thread;
        bus.unit_rd[u]     = rd;
        bus.unit_data[u]   = data;
    endtask

    task automatic clearStimulus();
        for (int u = 0; u < NU; u++)
            applyStimulus(u, 1'b0, 2'd0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [1:0] th,
                              input logic [4:0] rd, input logic [31:0] d);
        checkOutput({tag, ".wr_en"},        64'(bus.wr_en),        64'(en));
        checkOutput({tag, ".thread_rd_id"}, 64'(bus.thread_rd_id), 64'(th));
        checkOutput({tag, ".rd_addr"},      64'(bus.rd_addr),      64'(rd));
        checkOutput({tag, ".new_data"},     64'(bus.new_data),     64'(d));
    endtask

    task automatic checkBypass(input string tag, input logic v, input logic [1:0] th,
                               input logic [4:0] rd, input logic [31:0] d);
`ifdef REGFILE_WB_BYPASS_EN
        checkOutput({tag, ".byp_valid"},  64'(bus.byp_valid),  64'(v));
        checkOutput({tag, ".byp_thread"}, 64'(bus.byp_thread), 64'(th));
        checkOutput({tag, ".byp_rd"},     64'(bus.byp_rd),     64'(rd));
        checkOutput({tag, ".byp_data"},   64'(bus.byp_data),   64'(d));
`else
        checkOutput({tag, ".byp_valid"},  64'(bus.byp_valid),  64'(1'b0 & v));
        checkOutput({tag, ".byp_thread"}, 64'(bus.byp_thread), 64'(2'd0 & th));
        checkOutput({tag, ".byp_rd"},     64'(bus.byp_rd),     64'(5'd0 & rd));
        checkOutput({tag, ".byp_data"},   64'(bus.byp_data),   64'(32'd0 & d));
`endif
    endtask

    function automatic logic [4:0] entry_rd(input int u, input int e);
        return 5'(1 + u * 8 + e);
    endfunction

    function automatic logic [31:0] entry_data(input int u, input int e);
        return 32'hA000_0000 + 32'(u * 256 + e);
    endfunction

    initial begin
        clearStimulus();
        rst = 1'b1;
        repeat (2) tick();
        checkWrite("reset", 1'b0, 2'd0, 5'd0, 32'd0);
        checkBypass("reset", 1'b0, 2'd0, 5'd0, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset.ready", 64'(bus.unit_ready), 64'(3'b111));

        // Single write from unit0: visible two edges after acceptance, for one cycle.
        applyStimulus(0, 1'b1, 2'd2, 5'd5, 32'hDEAD_BEEF);
        tick();
        clearStimulus();
        checkOutput("t1.accept.wr_en", 64'(bus.wr_en), 64'(1'b0));
        tick();
        checkWrite("t1.write", 1'b1, 2'd2, 5'd5, 32'hDEAD_BEEF);
        checkBypass("t1.byp_idle", 1'b0, 2'd0, 5'd0, 32'd0);
        tick();
        checkWrite("t1.after", 1'b0, 2'd2, 5'd5, 32'hDEAD_BEEF);
        checkBypass("t1.byp", 1'b1, 2'd2, 5'd5, 32'hDEAD_BEEF);

        // All three units at once from rr_ptr=0, then confirm the pointer wrapped back to 0.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int u = 0; u < NU; u++)
            applyStimulus(u, 1'b1, 2'(u), 5'(10 + u), 32'(32'h100 + u));
        tick();
        clearStimulus();
        for (int u = 0; u < NU; u++) begin
            tick();
            checkWrite($sformatf("t2.u%0d", u), 1'b1, 2'(u), 5'(10 + u), 32'(32'h100 + u));
        end
        tick();
        checkOutput("t2.idle.wr_en", 64'(bus.wr_en), 64'(1'b0));
        applyStimulus(2, 1'b1, 2'd2, 5'd22, 32'h202);
        applyStimulus(0, 1'b1, 2'd0, 5'd20, 32'h200);
        tick();
        clearStimulus();
        tick();
        checkWrite("t2.rr_first", 1'b1, 2'd0, 5'd20, 32'h200);
        tick();
        checkWrite("t2.rr_second", 1'b1, 2'd2, 5'd22, 32'h202);

        // Saturation: all units push five entries; unit1 then offers a sixth while full.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k <= 5) begin
                for (int u = 0; u < NU; u++)
                    applyStimulus(u, 1'b1, 2'(u), entry_rd(u, k - 1), entry_data(u, k - 1));
            end else if (k == 6) begin
                clearStimulus();
                checkOutput("t3.ready_full", 64'(bus.unit_ready), 64'(3'b001));
                applyStimulus(1, 1'b1, 2'd1, entry_rd(1, 5), entry_data(1, 5));
            end else begin
                clearStimulus();
            end
            tick();
            if (k == 6)
                checkOutput("t3.ready_drain", 64'(bus.unit_ready), 64'(3'b011));
            if (k >= 2)
                checkWrite($sformatf("t3.w%0d", k - 2), 1'b1, 2'((k - 2) % 3),
                           entry_rd((k - 2) % 3, (k - 2) / 3), entry_data((k - 2) % 3, (k - 2) / 3));
        end
        tick();
        checkOutput("t3.no_extra.wr_en", 64'(bus.wr_en), 64'(1'b0));
        tick();
        checkOutput("t3.idle.wr_en", 64'(bus.wr_en), 64'(1'b0));

        // r0 destination consumes a slot silently; the following entry writes next cycle.
        applyStimulus(0, 1'b1, 2'd0, 5'd0, 32'h1234);
        tick();
        applyStimulus(0, 1'b1, 2'd3, 5'd9, 32'h99);
        tick();
        clearStimulus();
        checkWrite("t4.rd0", 1'b0, 2'd0, 5'd0, 32'h1234);
        tick();
        checkWrite("t4.next", 1'b1, 2'd3, 5'd9, 32'h99);

        // Flush with three entries queued and a push offered during the flush cycle.
        for (int u = 0; u < NU; u++)
            applyStimulus(u, 1'b1, 2'(u), 5'(15 + u), 32'(32'h500 + u));
        tick();
        clearStimulus();
        flush = 1'b1;
        applyStimulus(2, 1'b1, 2'd2, 5'd30, 32'hBAD);
        tick();
        flush = 1'b0;
        clearStimulus();
        checkOutput("t5.flush.wr_en", 64'(bus.wr_en), 64'(1'b0));
        checkOutput("t5.flush.ready", 64'(bus.unit_ready), 64'(3'b111));
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput($sformatf("t5.post%0d.wr_en", c), 64'(bus.wr_en), 64'(1'b0));
        end

        // Forwarding port follows the write port by one cycle.
        applyStimulus(0, 1'b1, 2'd1, 5'd7, 32'h55);
        tick();
        clearStimulus();
        tick();
        checkWrite("t6.write", 1'b1, 2'd1, 5'd7, 32'h55);
        tick();
        checkOutput("t6.after.wr_en", 64'(bus.wr_en), 64'(1'b0));
        checkBypass("t6.byp", 1'b1, 2'd1, 5'd7, 32'h55);

        // Asynchronous reset mid-operation drops the queued entry.
        applyStimulus(0, 1'b1, 2'd2, 5'd3, 32'h77);
        tick();
        applyStimulus(0, 1'b1, 2'd2, 5'd4, 32'h88);
        tick();
        clearStimulus();
        checkWrite("t7.pre", 1'b1, 2'd2, 5'd3, 32'h77);
        #2 rst = 1'b1;
        #1;
        checkWrite("t7.async", 1'b0, 2'd0, 5'd0, 32'd0);
        checkBypass("t7.async", 1'b0, 2'd0, 5'd0, 32'd0);
        checkOutput("t7.async.ready", 64'(bus.unit_ready), 64'(3'b111));
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("t7.post%0d.wr_en", c), 64'(bus.wr_en), 64'(1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end
endmodule
